ram_capture: RTL and testbench

//  Write-side counterpart to the .mem-initialised read-only store. Captures a byte

---
 rtl/ram_capture_if.sv | 42 ++++
 rtl/ram_capture.sv | 109 ++++++++++
 tb/tb_ram_capture.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ram_capture_if.sv
// Bus bundle for ram_capture: capture control, byte stream, read port and status.
// Optional checksum output appears when RAM_CAPTURE_CHECKSUM_EN is defined.
interface ram_capture_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
);
  logic                 start;
  logic [ADDR_BITS:0]   len;
  // Stream handshake: a byte moves on any posedge where in_valid && in_ready;
  // in_data must be stable while in_valid is high, in_ready never depends on in_valid.
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [DATA_BITS-1:0] rd_data;
  logic [ADDR_BITS:0]   count;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [1:0]           fsm_state;
`ifdef RAM_CAPTURE_CHECKSUM_EN
  logic [DATA_BITS-1:0] checksum;

  modport master (
    output start, len, in_data, in_valid, rd_addr,
    input  in_ready, rd_data, count, busy, done, overflow, fsm_state, checksum
  );
  modport slave (
    input  start, len, in_data, in_valid, rd_addr,
    output in_ready, rd_data, count, busy, done, overflow, fsm_state, checksum
  );
`else
  modport master (
    output start, len, in_data, in_valid, rd_addr,
    input  in_ready, rd_data, count, busy, done, overflow, fsm_state
  );
  modport slave (
    input  start, len, in_data, in_valid, rd_addr,
    output in_ready, rd_data, count, busy, done, overflow, fsm_state
  );
`endif
endinterface

// File: rtl/ram_capture.sv
// Captures a byte stream into an internal RAM from address 0, bounded by a requested length.
// Optional running checksum of captured bytes: define RAM_CAPTURE_CHECKSUM_EN.
module ram_capture #(
  parameter int SIZE      = 256,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input logic         clk,
  input logic         rst,
  ram_capture_if.slave bus
);
  localparam int            CW     = ADDR_BITS + 1;
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [CW-1:0]        target;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [DATA_BITS-1:0] rd_data;
  logic [DATA_BITS-1:0] mem [SIZE];
  logic                 xfer;
`ifdef RAM_CAPTURE_CHECKSUM_EN
  logic [DATA_BITS-1:0] checksum;
`endif

  assign bus.in_ready  = busy && (count < target);
  assign xfer          = bus.in_valid && bus.in_ready;
  assign bus.rd_data   = rd_data;
  assign bus.count     = count;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.overflow  = overflow;
  assign bus.fsm_state = state;
`ifdef RAM_CAPTURE_CHECKSUM_EN
  assign bus.checksum  = checksum;
`endif

  // start takes priority over a same-edge transfer, so a restart discards that byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      target   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
`ifdef RAM_CAPTURE_CHECKSUM_EN
      checksum <= '0;
`endif
    end else if (bus.start) begin
      state    <= CAPTURE;
      busy     <= 1'b1;
      done     <= 1'b0;
      count    <= '0;
      target   <= (bus.len > SIZE_C) ? SIZE_C : bus.len;
      overflow <= (bus.len > SIZE_C);
`ifdef RAM_CAPTURE_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      case (state)
        CAPTURE: begin
          if (xfer) begin
            count <= count + ONE;
`ifdef RAM_CAPTURE_CHECKSUM_EN
            checksum <= checksum + bus.in_data;
`endif
            if ((count + ONE) == target) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (count >= target) begin
            // zero-length capture: nothing to accept, finish immediately
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM is deliberately not reset; count < target <= SIZE keeps the index in range.
  always_ff @(posedge clk) begin
    if (xfer && !bus.start && !rst) begin
      mem[count[ADDR_BITS-1:0]] <= bus.in_data;
    end
  end

  // Read-first: a same-edge write to rd_addr is seen on the following read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[bus.rd_addr];
    end
  end
endmodule

// File: tb/tb_ram_capture.sv
// Directed-vector bench for ram_capture (SIZE=8): per-cycle table plus RAM readback and checksum sequences.
module tb_ram_capture;
  localparam int SIZE = 8;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int CW   = AW + 1;

  logic clk = 1'b0;
  logic rst;

  ram_capture_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus();

  ram_capture #(.SIZE(SIZE), .DATA_BITS(DW), .ADDR_BITS(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          valid;
    logic [DW-1:0] data;
    logic [AW-1:0] ra;
    logic          exp_ready;
    logic [CW-1:0] exp_count;
    logic          exp_busy;
    logic          exp_done;
    logic          exp_ovf;
    logic          chk_rd;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle, then sample just after the edge.
  task automatic drive(input logic r, input logic s, input logic [CW-1:0] l,
                       input logic v, input logic [DW-1:0] d, input logic [AW-1:0] ra);
    rst          = r;
    bus.start    = s;
    bus.len      = l;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.rd_addr  = ra;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int r, input int s, input int l, input int v, input int d,
                              input int ra, input int er, input int ec, input int eb,
                              input int ed, input int eo, input int cr, input int erd);
    vec_t t;
    t.rst = r[0];  t.start = s[0];  t.len = CW'(l);  t.valid = v[0];
    t.data = DW'(d);  t.ra = AW'(ra);
    t.exp_ready = er[0];  t.exp_count = CW'(ec);  t.exp_busy = eb[0];
    t.exp_done = ed[0];   t.exp_ovf = eo[0];      t.chk_rd = cr[0];  t.exp_rd = DW'(erd);
    return t;
  endfunction

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.rd_addr = '0;

    //               rst st len v  data  ra | rdy cnt busy done ovf chk rd
    // len=4 back-to-back, then ignored byte in DONE and readback
    vecs.push_back(mk(1, 0, 0, 0, 'h00, 0,  0, 0, 0, 0, 0, 1, 'h00));
    vecs.push_back(mk(0, 1, 4, 0, 'h00, 0,  1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'h11, 0,  1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'h22, 0,  1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'h33, 0,  1, 3, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'h44, 0,  0, 4, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'h55, 2,  0, 4, 0, 1, 0, 1, 'h33));
    vecs.push_back(mk(0, 0, 0, 0, 'h00, 3,  0, 4, 0, 1, 0, 1, 'h44));
    vecs.push_back(mk(0, 0, 0, 0, 'h00, 0,  0, 4, 0, 1, 0, 1, 'h11));
    // len=3 with in_valid toggling
    vecs.push_back(mk(0, 1, 3, 0, 'h00, 0,  1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'hA1, 0,  1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'hFF, 0,  1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'hA2, 0,  1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'hFF, 0,  1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'hA3, 0,  0, 3, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'h00, 1,  0, 3, 0, 1, 0, 1, 'hA2));
    vecs.push_back(mk(0, 0, 0, 0, 'h00, 2,  0, 3, 0, 1, 0, 1, 'hA3));
    vecs.push_back(mk(0, 0, 0, 0, 'h00, 3,  0, 3, 0, 1, 0, 1, 'h44));
    // len=0: one busy cycle, then done without writes
    vecs.push_back(mk(0, 1, 0, 0, 'h00, 0,  0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'hEE, 0,  0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'h00, 0,  0, 0, 0, 1, 0, 1, 'hA1));
    // len=12 > SIZE: 8 accepted, rest refused, overflow sticky
    vecs.push_back(mk(0, 1, 12, 0, 'h00, 0, 1, 0, 1, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, 0, 1, 'hB0 + i, 0, (i < 7) ? 1 : 0, i + 1,
                        (i < 7) ? 1 : 0, (i == 7) ? 1 : 0, 1, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 1, 'hF8 + i, 0, 0, 8, 0, 1, 1, 0, 0));
    // restart mid-capture: start wins over the same-edge byte
    vecs.push_back(mk(0, 1, 5, 0, 'h00, 0,  1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'hC0, 0,  1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'hC1, 0,  1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, 'hDD, 0,  1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'h00, 0,  1, 0, 1, 0, 0, 1, 'hC0));
    vecs.push_back(mk(0, 0, 0, 1, 'hE0, 0,  1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'hE1, 0,  0, 2, 0, 1, 0, 0, 0));
    // reset mid-capture, recapture two bytes; read-first on the write address
    vecs.push_back(mk(0, 1, 5, 0, 'h00, 0,  1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'h01, 0,  1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'h02, 0,  1, 2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 'h03, 0,  0, 0, 0, 0, 0, 1, 'h00));
    vecs.push_back(mk(0, 1, 2, 0, 'h00, 0,  1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'hAA, 0,  1, 1, 1, 0, 0, 1, 'h01));
    vecs.push_back(mk(0, 0, 0, 1, 'hBB, 1,  0, 2, 0, 1, 0, 1, 'h02));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].len, vecs[i].valid, vecs[i].data, vecs[i].ra);
      check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d count", i),    32'(bus.count),    32'(vecs[i].exp_count));
      check($sformatf("v%0d busy", i),     32'(bus.busy),     32'(vecs[i].exp_busy));
      check($sformatf("v%0d done", i),     32'(bus.done),     32'(vecs[i].exp_done));
      check($sformatf("v%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
      if (vecs[i].chk_rd)
        check($sformatf("v%0d rd_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_rd));
    end

    // Full RAM readback: AA,BB from the last capture, B2..B7 survive reset and restarts.
    exp_q = '{8'hAA, 8'hBB, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
    for (int a = 0; a < SIZE; a++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0, AW'(a));
      check($sformatf("ram[%0d]", a), 32'(bus.rd_data), 32'(exp_q.pop_front()));
    end

`ifdef RAM_CAPTURE_CHECKSUM_EN
    drive(1'b0, 1'b1, CW'(3), 1'b0, '0, '0);
    check("csum after start", 32'(bus.checksum), 32'h00);
    drive(1'b0, 1'b0, '0, 1'b1, 8'hF0, '0);
    drive(1'b0, 1'b0, '0, 1'b1, 8'h20, '0);
    drive(1'b0, 1'b0, '0, 1'b1, 8'h05, '0);
    check("csum done", 32'(bus.done), 32'h1);
    check("csum value", 32'(bus.checksum), 32'h15);
    drive(1'b0, 1'b1, CW'(1), 1'b0, '0, '0);
    check("csum cleared", 32'(bus.checksum), 32'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
